game_sequencer: RTL and testbench
=================================

# game_sequencer

Top-level game sequencer for the car/frog playfield. It owns the game state machine (title, play, level-up pause, death pause, game over) and tracks level and lives. It drives the level-dependent `speed_car` value and a single-cycle movement tick that gates all car position updates. It sits between the input/collision logic and `car_control`, replacing free-running car motion with motion that runs only while the game is in play.

## Interface
Parameters:
- `TICK_PERIOD`, 500000: clock cycles between car movement ticks (19-bit counter, ≤ 2^19).
- `PAUSE_CYCLES`, 25000000: length in cycles of the LEVEL_UP and DEAD pauses (25-bit counter).
- `LIVES_INIT`, 3: lives at game start (1..3).
- `MAX_LEVEL`, 8: highest level (2..15).
- `SPEED_STEP`, 2: `speed_car` increment per level.

Ports:
- `CLK`  in  1  system clock.
- `RST`  in  1  synchronous, active-high reset.
- `i_start`  in  1  one-cycle start pulse (debounced button).
- `i_goal`  in  1  one-cycle pulse: frog reached top row.
- `i_collision`  in  1  one-cycle pulse: frog hit by a car.
- `o_state`  out  3  current state: IDLE=0, PLAY=1, LEVEL_UP=2, DEAD=3, GAME_OVER=4.
- `o_level`  out  4  current level, 1..MAX_LEVEL.
- `o_lives`  out  2  remaining lives.
- `speed_car`  out  5  extra car speed fed to `car_control`.
- `o_car_tick`  out  1  one-cycle enable for a car position step.
- `o_frog_reset`  out  1  one-cycle pulse: return the frog to its start position.

## Operation
- All outputs are registered.
- Reset values:
  - state IDLE, level 1, lives LIVES_INIT, `speed_car` 0.
  - `o_car_tick` 0, `o_frog_reset` 0.
  - tick and pause counters 0.
- `speed_car` = min((level−1)·SPEED_STEP, 31). It is computed from the next level value and updates on the same edge as `o_level`.
- IDLE and GAME_OVER:
  - `i_start` sets level 1, lives LIVES_INIT, `speed_car` 0, and moves to PLAY.
  - `i_goal` and `i_collision` are ignored.
- PLAY:
  - The tick counter runs and `o_car_tick` pulses.
  - `i_collision` decrements lives:
    - if the result is 0, go to GAME_OVER;
    - otherwise go to DEAD.
  - `i_goal` goes to LEVEL_UP and sets level = min(level+1, MAX_LEVEL). At MAX_LEVEL the level saturates and LEVEL_UP is still entered.
  - If `i_collision` and `i_goal` arrive in the same cycle, the collision wins and the goal is discarded.
  - `i_start` is ignored.
- LEVEL_UP and DEAD:
  - The pause counter counts PAUSE_CYCLES cycles, then the state returns to PLAY.
  - All inputs are ignored.
- `o_frog_reset` is high for exactly the first cycle of every PLAY entry, from IDLE, GAME_OVER, LEVEL_UP or DEAD.
- Outside PLAY:
  - `o_car_tick` is held at 0 and the tick counter is held at 0.
  - Cars freeze, and their positions are retained by `car_control`.
- RST asserted in any state, including mid-pause or mid-tick-period, restores all reset values on the next edge. Pending input pulses are dropped.

## Timing
- Input-to-state latency is 1 cycle: a pulse sampled at edge N gives the new `o_state`, `o_level`, `o_lives` and `speed_car` after edge N.
- Tick counter:
  - It is cleared on PLAY entry and counts 0..TICK_PERIOD−1, wrapping to 0.
  - `o_car_tick` is high in the cycle after the counter equals TICK_PERIOD−1.
  - The first tick comes exactly TICK_PERIOD cycles after the first PLAY cycle, then every TICK_PERIOD cycles.
  - A state exit on the same edge as a tick suppresses that tick.
- Pause counter:
  - It is cleared on pause entry.
  - The pause state lasts exactly PAUSE_CYCLES cycles; the next cycle is PLAY with `o_frog_reset` = 1.
- Both counters saturate-safe: a counter never exceeds its terminal value, and there is no wrap-around outside the defined range.
- `o_frog_reset` and `o_car_tick` are never high for two consecutive cycles.

## Test plan
Bench parameters: TICK_PERIOD=4, PAUSE_CYCLES=3, LIVES_INIT=3, MAX_LEVEL=3, SPEED_STEP=2.
- Reset, then 10 idle cycles -> state 0, level 1, lives 3, `speed_car` 0, no tick, no `o_frog_reset`. Pulse `i_goal`/`i_collision` -> no change.
- `i_start` -> state 1 next cycle with `o_frog_reset`=1 for 1 cycle. `o_car_tick` first high 4 cycles after PLAY entry, then every 4 cycles, for 20 cycles.
- In PLAY, `i_goal` ×3 (each after its pause) -> level 2/`speed_car` 2, then level 3/4, then level 3/4 again (saturated). Each pause lasts 3 cycles with no ticks, then `o_frog_reset`=1.
- `i_collision` and `i_goal` in the same cycle -> state 3, lives 2, level unchanged.
- Three collisions -> lives 2 then 1, then state 4 with lives 0. Then `i_start` -> state 1, level 1, lives 3, `speed_car` 0, `o_frog_reset`=1.
- RST asserted mid-DEAD pause (cycle 2 of 3) and mid-tick-period -> next cycle all reset values, no tick or `o_frog_reset` emitted.

Source files
------------

// File: rtl/game_sequencer_if.sv
// ---------------------------------------------------------------------------
// game_sequencer_if
//
// Groups the game sequencer's event inputs and status outputs into one bundle.
//
// Signals:
//   i_start      event  one-cycle start pulse (debounced button)
//   i_goal       event  one-cycle pulse, frog reached the top row
//   i_collision  event  one-cycle pulse, frog hit by a car
//   o_state      status current game state (IDLE=0, PLAY=1, LEVEL_UP=2,
//                       DEAD=3, GAME_OVER=4)
//   o_level      status current level, 1..MAX_LEVEL
//   o_lives      status remaining lives
//   speed_car    status extra car speed for car_control
//   o_car_tick   status one-cycle enable for a car position step
//   o_frog_reset status one-cycle pulse, return the frog to its start
//
// Modports:
//   master : the environment side (drives events, observes status)
//   slave  : the sequencer side (observes events, drives status)
// ---------------------------------------------------------------------------
interface game_sequencer_if;
    logic       i_start;
    logic       i_goal;
    logic       i_collision;
    logic [2:0] o_state;
    logic [3:0] o_level;
    logic [1:0] o_lives;
    logic [4:0] speed_car;
    logic       o_car_tick;
    logic       o_frog_reset;

    modport master (
        output i_start,
        output i_goal,
        output i_collision,
        input  o_state,
        input  o_level,
        input  o_lives,
        input  speed_car,
        input  o_car_tick,
        input  o_frog_reset
    );

    modport slave (
        input  i_start,
        input  i_goal,
        input  i_collision,
        output o_state,
        output o_level,
        output o_lives,
        output speed_car,
        output o_car_tick,
        output o_frog_reset
    );
endinterface

// File: rtl/game_sequencer.sv
// ---------------------------------------------------------------------------
// game_sequencer
//
// Game state machine for the car/frog playfield. Tracks level and lives,
// produces the level-dependent car speed and a periodic car movement tick
// that only runs while the game is in play, and pulses a frog reset on every
// entry into play.
//
// Ports:
//   CLK  system clock
//   RST  synchronous, active-high reset
//   bus  game_sequencer_if.slave
//          in : i_start, i_goal, i_collision (one-cycle pulses)
//          out: o_state, o_level, o_lives, speed_car, o_car_tick,
//               o_frog_reset (all registered)
//
// Parameters:
//   TICK_PERIOD   cycles between car ticks while in play (<= 2^19)
//   PAUSE_CYCLES  length of the LEVEL_UP and DEAD pauses (<= 2^25)
//   LIVES_INIT    lives at game start (1..3)
//   MAX_LEVEL     highest level (2..15)
//   SPEED_STEP    speed_car increment per level
// ---------------------------------------------------------------------------
module game_sequencer #(
    parameter int TICK_PERIOD  = 500000,
    parameter int PAUSE_CYCLES = 25000000,
    parameter int LIVES_INIT   = 3,
    parameter int MAX_LEVEL    = 8,
    parameter int SPEED_STEP   = 2
) (
    input  logic           CLK,
    input  logic           RST,
    game_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PLAY      = 3'd1,
        S_LEVEL_UP  = 3'd2,
        S_DEAD      = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    localparam logic [18:0] TICK_LAST   = 19'(TICK_PERIOD - 1);
    localparam logic [24:0] PAUSE_LAST  = 25'(PAUSE_CYCLES - 1);
    localparam logic [3:0]  LEVEL_MAX   = 4'(MAX_LEVEL);
    localparam logic [1:0]  LIVES_START = 2'(LIVES_INIT);

    // Next level after a goal, held at MAX_LEVEL once reached.
    function automatic logic [3:0] level_inc_sat(input logic [3:0] lvl);
        if (lvl >= LEVEL_MAX) begin
            return LEVEL_MAX;
        end
        return lvl + 4'd1;
    endfunction

    // speed_car = min((level-1)*SPEED_STEP, 31); level is never 0.
    function automatic logic [4:0] speed_for_level(input logic [3:0] lvl);
        logic [31:0] steps;
        steps = (32'(lvl) - 32'd1) * 32'(SPEED_STEP);
        if (steps > 32'd31) begin
            return 5'd31;
        end
        return steps[4:0];
    endfunction

    // Lives decrement that cannot wrap below zero.
    function automatic logic [1:0] lives_dec_sat(input logic [1:0] lv);
        if (lv == 2'd0) begin
            return 2'd0;
        end
        return lv - 2'd1;
    endfunction

    state_t      state_q,      state_d;
    logic [3:0]  level_q,      level_d;
    logic [1:0]  lives_q,      lives_d;
    logic [4:0]  speed_q,      speed_d;
    logic [18:0] tick_cnt_q,   tick_cnt_d;
    logic [24:0] pause_cnt_q,  pause_cnt_d;
    logic        car_tick_q,   car_tick_d;
    logic        frog_reset_q, frog_reset_d;

    // Next-state, counters and output decode
    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        lives_d      = lives_q;
        tick_cnt_d   = '0;
        pause_cnt_d  = '0;
        car_tick_d   = 1'b0;
        frog_reset_d = 1'b0;

        case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (bus.i_start) begin
                    state_d = S_PLAY;
                    level_d = 4'd1;
                    lives_d = LIVES_START;
                end
            end

            S_PLAY: begin
                // A collision in the same cycle as a goal takes priority.
                if (bus.i_collision) begin
                    lives_d = lives_dec_sat(lives_q);
                    state_d = (lives_d == 2'd0) ? S_GAME_OVER : S_DEAD;
                end else if (bus.i_goal) begin
                    state_d = S_LEVEL_UP;
                    level_d = level_inc_sat(level_q);
                end
            end

            S_LEVEL_UP, S_DEAD: begin
                // The pause counter arrives here at 0 because it is held
                // cleared in every other state.
                if (pause_cnt_q >= PAUSE_LAST) begin
                    state_d = S_PLAY;
                end else begin
                    pause_cnt_d = pause_cnt_q + 25'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The tick counter only advances across PLAY->PLAY edges, so it is
        // zero on the first PLAY cycle and a tick coinciding with a state
        // exit is never emitted.
        if ((state_q == S_PLAY) && (state_d == S_PLAY)) begin
            if (tick_cnt_q >= TICK_LAST) begin
                tick_cnt_d = '0;
                car_tick_d = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + 19'd1;
            end
        end

        frog_reset_d = (state_d == S_PLAY) && (state_q != S_PLAY);

        // Speed follows the level it will be registered alongside.
        speed_d = speed_for_level(level_d);
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            level_q      <= 4'd1;
            lives_q      <= LIVES_START;
            speed_q      <= 5'd0;
            tick_cnt_q   <= '0;
            pause_cnt_q  <= '0;
            car_tick_q   <= 1'b0;
            frog_reset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            lives_q      <= lives_d;
            speed_q      <= speed_d;
            tick_cnt_q   <= tick_cnt_d;
            pause_cnt_q  <= pause_cnt_d;
            car_tick_q   <= car_tick_d;
            frog_reset_q <= frog_reset_d;
        end
    end

    assign bus.o_state      = state_q;
    assign bus.o_level      = level_q;
    assign bus.o_lives      = lives_q;
    assign bus.speed_car    = speed_q;
    assign bus.o_car_tick   = car_tick_q;
    assign bus.o_frog_reset = frog_reset_q;

endmodule

// File: tb/tb_game_sequencer.sv
// ---------------------------------------------------------------------------
// tb_game_sequencer
//
// Directed bench for game_sequencer with TICK_PERIOD=4, PAUSE_CYCLES=3,
// LIVES_INIT=3, MAX_LEVEL=3, SPEED_STEP=2. Inputs change just after a falling
// edge and outputs are sampled on falling edges.
// ---------------------------------------------------------------------------
module tb_game_sequencer;

    localparam int TP = 4;
    localparam int PC = 3;
    localparam int LI = 3;
    localparam int ML = 3;
    localparam int SS = 2;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    game_sequencer_if bus ();

    game_sequencer #(
        .TICK_PERIOD  (TP),
        .PAUSE_CYCLES (PC),
        .LIVES_INIT   (LI),
        .MAX_LEVEL    (ML),
        .SPEED_STEP   (SS)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic chk_all(input string tag, input int st, input int lvl, input int lv,
                           input int spd, input int tick, input int frog);
        chk_eq($sformatf("%s.state", tag), 32'(bus.o_state), st);
        chk_eq($sformatf("%s.level", tag), 32'(bus.o_level), lvl);
        chk_eq($sformatf("%s.lives", tag), 32'(bus.o_lives), lv);
        chk_eq($sformatf("%s.speed", tag), 32'(bus.speed_car), spd);
        chk_eq($sformatf("%s.tick",  tag), 32'(bus.o_car_tick), tick);
        chk_eq($sformatf("%s.frog",  tag), 32'(bus.o_frog_reset), frog);
    endtask

    // Called at the first pause cycle; returns at the first PLAY cycle.
    task automatic check_pause(input string tag, input int st, input int lvl,
                               input int lv, input int spd);
        for (int i = 0; i < PC; i++) begin
            chk_all($sformatf("%s.p%0d", tag, i), st, lvl, lv, spd, 0, 0);
            step();
        end
        chk_all($sformatf("%s.ret", tag), 1, lvl, lv, spd, 0, 1);
    endtask

    initial begin
        RST             = 1'b1;
        bus.i_start     = 1'b0;
        bus.i_goal      = 1'b0;
        bus.i_collision = 1'b0;
        step();
        step();
        chk_all("reset", 0, 1, 3, 0, 0, 0);
        RST = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step();
            chk_all($sformatf("idle%0d", i), 0, 1, 3, 0, 0, 0);
        end

        bus.i_goal = 1'b1;
        step();
        bus.i_goal = 1'b0;
        chk_all("idle_goal", 0, 1, 3, 0, 0, 0);
        bus.i_collision = 1'b1;
        step();
        bus.i_collision = 1'b0;
        chk_all("idle_col", 0, 1, 3, 0, 0, 0);

        // Start: first PLAY cycle carries the frog reset, ticks every 4 cycles.
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        chk_all("start", 1, 1, 3, 0, 0, 1);
        for (int k = 1; k <= 20; k++) begin
            step();
            chk_eq($sformatf("tick%0d", k), 32'(bus.o_car_tick), (k % 4 == 0) ? 1 : 0);
            chk_eq($sformatf("frog%0d", k), 32'(bus.o_frog_reset), 0);
            chk_eq($sformatf("play%0d", k), 32'(bus.o_state), 1);
        end

        // Goals: level 2 / speed 2, level 3 / speed 4, then saturated.
        bus.i_goal = 1'b1;
        step();
        bus.i_goal = 1'b0;
        check_pause("lvl2", 2, 2, 3, 2);

        bus.i_goal = 1'b1;
        step();
        bus.i_goal = 1'b0;
        check_pause("lvl3", 2, 3, 3, 4);

        // Goal on the edge that would produce a tick: tick is suppressed.
        for (int k = 1; k <= 3; k++) begin
            step();
            chk_eq($sformatf("pre_sat_tick%0d", k), 32'(bus.o_car_tick), 0);
        end
        bus.i_goal = 1'b1;
        step();
        bus.i_goal = 1'b0;
        check_pause("lvlsat", 2, 3, 3, 4);

        // Collision and goal together: collision wins.
        bus.i_goal      = 1'b1;
        bus.i_collision = 1'b1;
        step();
        bus.i_goal      = 1'b0;
        bus.i_collision = 1'b0;
        check_pause("both", 3, 3, 2, 4);

        bus.i_collision = 1'b1;
        step();
        bus.i_collision = 1'b0;
        check_pause("col2", 3, 3, 1, 4);

        bus.i_collision = 1'b1;
        step();
        bus.i_collision = 1'b0;
        chk_all("over", 4, 3, 0, 4, 0, 0);
        step();
        chk_all("over_hold", 4, 3, 0, 4, 0, 0);
        bus.i_goal = 1'b1;
        step();
        bus.i_goal = 1'b0;
        chk_all("over_goal", 4, 3, 0, 4, 0, 0);

        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        chk_all("restart", 1, 1, 3, 0, 0, 1);

        // Reset on the cycle before a tick would appear.
        for (int k = 1; k <= 3; k++) begin
            step();
        end
        chk_eq("pre_rst_state", 32'(bus.o_state), 1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk_all("rst_tick", 0, 1, 3, 0, 0, 0);
        step();
        chk_all("rst_tick2", 0, 1, 3, 0, 0, 0);

        // Reset in the second DEAD pause cycle, with a goal pending.
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        chk_all("start2", 1, 1, 3, 0, 0, 1);
        bus.i_collision = 1'b1;
        step();
        bus.i_collision = 1'b0;
        chk_all("dead", 3, 1, 2, 0, 0, 0);
        step();
        RST        = 1'b1;
        bus.i_goal = 1'b1;
        step();
        RST        = 1'b0;
        bus.i_goal = 1'b0;
        chk_all("rst_dead", 0, 1, 3, 0, 0, 0);
        step();
        chk_all("rst_dead2", 0, 1, 3, 0, 0, 0);
        step();
        chk_all("rst_dead3", 0, 1, 3, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
